// File: rtl/array_multiplier_pipe.sv
// Pipelined WIDTH x WIDTH array multiplier, per-beat signed/unsigned, valid/ready with bubble collapse.
// Define COMB_OUT_EN to add the flat combinational product port Z.
module array_multiplier_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_valid,
  output logic               i_ready,
  input  logic               i_signed,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               o_valid,
  input  logic               o_ready,
`ifdef COMB_OUT_EN
  output logic [2*WIDTH-1:0] Z,
`endif
  output logic [2*WIDTH-1:0] Z_reg
);

  localparam int PW   = 2 * WIDTH;
  localparam int ROWS = WIDTH / STAGES;

  // Sum of n partial-product rows starting at row lo. In signed mode the multiplicand is
  // sign-extended and the top row carries weight -2^(W-1), so the 2W-bit result is exact.
  function automatic logic [PW-1:0] rows_sum(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic sgn, input int lo, input int n);
    logic [PW-1:0]    row;
    logic [PW-1:0]    acc;
    logic [WIDTH-1:0] bb;
    row = (sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a}) << lo;
    bb  = b >> lo;
    acc = '0;
    for (int r = 0; r < n; r++) begin
      if (bb[0]) acc = (sgn && (lo + r == WIDTH - 1)) ? acc - row : acc + row;
      row = row << 1;
      bb  = bb >> 1;
    end
    return acc;
  endfunction

  logic [STAGES-1:0] v_q, v_d, adv;
  logic [PW-1:0]     sum_q [STAGES];
  logic [PW-1:0]     sum_d [STAGES];
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic              sgn_q [STAGES];
  logic              sgn_d [STAGES];

  logic              up_v   [STAGES];
  logic [PW-1:0]     up_sum [STAGES];
  logic [WIDTH-1:0]  up_a   [STAGES];
  logic [WIDTH-1:0]  up_b   [STAGES];
  logic              up_sgn [STAGES];

  for (genvar s = 0; s < STAGES; s++) begin : g_up
    if (s == 0) begin : g_in
      assign up_v[s]   = i_valid;
      assign up_sum[s] = '0;
      assign up_a[s]   = A;
      assign up_b[s]   = B;
      assign up_sgn[s] = i_signed;
    end else begin : g_chain
      assign up_v[s]   = v_q[s-1];
      assign up_sum[s] = sum_q[s-1];
      assign up_a[s]   = a_q[s-1];
      assign up_b[s]   = b_q[s-1];
      assign up_sgn[s] = sgn_q[s-1];
    end
  end

  // A stage may advance when any stage from it to the output is empty, or the output drains.
  always_comb begin
    adv = '0;
    for (int s = 0; s < STAGES; s++) begin
      adv[s] = o_ready;
      for (int k = s; k < STAGES; k++) begin
        if (!v_q[k]) adv[s] = 1'b1;
      end
    end
  end

  always_comb begin
    v_d   = v_q;
    sum_d = sum_q;
    a_d   = a_q;
    b_d   = b_q;
    sgn_d = sgn_q;
    for (int s = 0; s < STAGES; s++) begin
      if (adv[s]) begin
        v_d[s] = up_v[s];
        if (up_v[s]) begin
          sum_d[s] = up_sum[s] + rows_sum(up_a[s], up_b[s], up_sgn[s], s * ROWS, ROWS);
          a_d[s]   = up_a[s];
          b_d[s]   = up_b[s];
          sgn_d[s] = up_sgn[s];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      v_q             <= '0;
      sum_q[STAGES-1] <= '0;
    end else begin
      v_q   <= v_d;
      sum_q <= sum_d;
      a_q   <= a_d;
      b_q   <= b_d;
      sgn_q <= sgn_d;
    end
  end

  assign i_ready = adv[0];
  assign o_valid = v_q[STAGES-1];
  assign Z_reg   = sum_q[STAGES-1];

`ifdef COMB_OUT_EN
  assign Z = rows_sum(A, B, i_signed, 0, WIDTH);
`endif

endmodule
